// File: rtl/arb_mux2_pkg.sv
// Shared grant encodings, default counter width and the grant helper for arb_mux2.
// Used by the top and by the data-select mux.
package arb_mux2_pkg;

  localparam logic GNT_A = 1'b0;
  localparam logic GNT_B = 1'b1;

  localparam int CNT_W_DEFAULT = 16;

  // Round-robin on contention, otherwise follow the lone requester, else hold.
  function automatic logic next_grant(input logic a_valid, input logic b_valid,
                                      input logic last_gnt);
    logic gnt;
    gnt = last_gnt;
    if (a_valid && b_valid) begin
      gnt = ~last_gnt;
    end else if (a_valid) begin
      gnt = GNT_A;
    end else if (b_valid) begin
      gnt = GNT_B;
    end
    return gnt;
  endfunction

endpackage

// File: rtl/arb_mux2_mux.sv
// Purpose: parameterized 2:1 data select, b when s is GNT_B, otherwise a.
// Latency: purely combinational, zero cycles.
// Backpressure: none; selection only.
module arb_mux2_mux
  import arb_mux2_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  output logic [WIDTH-1:0] o
);

  assign o = (s == GNT_B) ? b : a;

endmodule

// File: rtl/arb_mux2.sv
// Purpose: round-robin 2-source arbiter feeding one registered output word; ARB_MUX2_CNT_EN adds per-source accept counters.
// Latency: 1 cycle from accepted handshake to o/o_valid.
// Backpressure: readies drop while o_valid && !o_ready; a simultaneous take and accept sustains one word per cycle.
module arb_mux2
  import arb_mux2_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] b,
  input  logic             b_valid,
  output logic             b_ready,
  output logic [WIDTH-1:0] o,
  output logic             o_valid,
  input  logic             o_ready,
  output logic             s
`ifdef ARB_MUX2_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
`endif
);

  logic             load;
  logic             last_gnt;
  logic             a_fire;
  logic             b_fire;
  logic [WIDTH-1:0] mux_o;

  assign load    = !o_valid || o_ready;
  assign s       = next_grant(a_valid, b_valid, last_gnt);
  assign a_ready = !rst && load && a_valid && (s == GNT_A);
  assign b_ready = !rst && load && b_valid && (s == GNT_B);
  assign a_fire  = a_valid && a_ready;
  assign b_fire  = b_valid && b_ready;

  arb_mux2_mux #(
    .WIDTH(WIDTH)
  ) u_mux (
    .a(a),
    .b(b),
    .s(s),
    .o(mux_o)
  );

  // last_gnt resets to B so that A wins the first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      o        <= '0;
      o_valid  <= 1'b0;
      last_gnt <= GNT_B;
    end else if (load) begin
      o_valid <= a_fire || b_fire;
      if (a_fire || b_fire) begin
        o        <= mux_o;
        last_gnt <= s;
      end
    end
  end

`ifdef ARB_MUX2_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else begin
      if (a_fire && (cnt_a != '1)) begin
        cnt_a <= cnt_a + 1'b1;
      end
      if (b_fire && (cnt_b != '1)) begin
        cnt_b <= cnt_b + 1'b1;
      end
    end
  end
`else
  if (CNT_W < 1) begin : g_cnt_w_chk
    $error("arb_mux2: CNT_W must be at least 1");
  end
`endif

endmodule

// File: tb/tb_arb_mux2.sv
// Bench for arb_mux2 (WIDTH=10, CNT_W=4); counter checks compile in with ARB_MUX2_CNT_EN.
module tb_arb_mux2;

  localparam int W  = 10;
  localparam int CW = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a, b, o;
  logic         a_valid, a_ready, b_valid, b_ready, o_valid, o_ready, s;
`ifdef ARB_MUX2_CNT_EN
  logic [CW-1:0] cnt_a, cnt_b;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] out_log[$];
  logic         m_ovld, m_last;
  int           m_cnt_a, m_cnt_b;
  logic         smp_ar, smp_br, smp_s;
  logic [W-1:0] smp_o;
  logic [W-1:0] held;

  arb_mux2 #(
    .WIDTH(W),
    .CNT_W(CW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .a_valid(a_valid),
    .a_ready(a_ready),
    .b      (b),
    .b_valid(b_valid),
    .b_ready(b_ready),
    .o      (o),
    .o_valid(o_valid),
    .o_ready(o_ready),
    .s      (s)
`ifdef ARB_MUX2_CNT_EN
    ,
    .cnt_a  (cnt_a),
    .cnt_b  (cnt_b)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One cycle: drive, check at negedge against the model, advance the model at posedge.
  task automatic step(input logic av, input logic [W-1:0] ad, input logic bv,
                      input logic [W-1:0] bd, input logic ordy, input logic r);
    logic m_load, m_s, m_ar, m_br;
    a_valid = av; a = ad; b_valid = bv; b = bd; o_ready = ordy; rst = r;
    @(negedge clk);
    smp_ar = a_ready; smp_br = b_ready; smp_s = s; smp_o = o;
    m_load = !m_ovld || ordy;
    if (av && bv)  m_s = ~m_last;
    else if (av)   m_s = 1'b0;
    else if (bv)   m_s = 1'b1;
    else           m_s = m_last;
    m_ar = !r && m_load && av && !m_s;
    m_br = !r && m_load && bv && m_s;
    check("s", s, m_s);
    check("a_ready", a_ready, m_ar);
    check("b_ready", b_ready, m_br);
    check("o_valid", o_valid, m_ovld);
    if (m_ovld) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", exp_q.size(), 1);
      end else begin
        check("o", o, exp_q[0]);
        if (ordy) out_log.push_back(exp_q.pop_front());
      end
    end
`ifdef ARB_MUX2_CNT_EN
    check("cnt_a", cnt_a, m_cnt_a);
    check("cnt_b", cnt_b, m_cnt_b);
`endif
    @(posedge clk);
    if (r) begin
      m_ovld = 1'b0; m_last = 1'b1; exp_q.delete(); m_cnt_a = 0; m_cnt_b = 0;
    end else if (m_load) begin
      if (m_ar) begin
        exp_q.push_back(ad); m_last = 1'b0;
        if (m_cnt_a < (1 << CW) - 1) m_cnt_a++;
      end
      if (m_br) begin
        exp_q.push_back(bd); m_last = 1'b1;
        if (m_cnt_b < (1 << CW) - 1) m_cnt_b++;
      end
      m_ovld = m_ar || m_br;
    end
    #1;
  endtask

  initial begin
    rst = 1'b1; a_valid = 1'b1; b_valid = 1'b1; a = 10'd1; b = 10'd2; o_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_a_ready", a_ready, 0);
    check("rst_b_ready", b_ready, 0);
    check("rst_o_valid", o_valid, 0);
    check("rst_o", o, 0);
    check("rst_s_first_contention", s, 0);
    m_ovld = 1'b0; m_last = 1'b1; m_cnt_a = 0; m_cnt_b = 0;
    @(posedge clk); #1;

    // Case 2: continuous contention alternates, starting with A.
    out_log.delete();
    repeat (5) step(1'b1, 10'd6, 1'b1, 10'd5, 1'b1, 1'b0);
    repeat (2) step(1'b0, 10'd0, 1'b0, 10'd0, 1'b1, 1'b0);
    check("c2_len", out_log.size(), 5);
    begin
      logic [W-1:0] want[4];
      want = '{10'd6, 10'd5, 10'd6, 10'd5};
      for (int i = 0; i < 4 && i < out_log.size(); i++) check("c2_seq", out_log[i], want[i]);
    end

    // Case 1: lone A request.
    step(1'b1, 10'd6, 1'b0, 10'd0, 1'b1, 1'b0);
    check("c1_a_ready", smp_ar, 1);
    check("c1_s", smp_s, 0);
    check("c1_o", o, 6);
    check("c1_o_valid", o_valid, 1);
    step(1'b0, 10'd0, 1'b0, 10'd0, 1'b1, 1'b0);

    // Case 3: three stalled cycles, then resume.
    step(1'b1, 10'd7, 1'b1, 10'd8, 1'b0, 1'b0);
    held = o;
    repeat (3) begin
      step(1'b1, 10'd7, 1'b1, 10'd8, 1'b0, 1'b0);
      check("c3_stable", smp_o, held);
      check("c3_readies", {smp_ar, smp_br}, 0);
    end
    repeat (4) step(1'b1, 10'd7, 1'b1, 10'd8, 1'b1, 1'b0);
    repeat (2) step(1'b0, 10'd0, 1'b0, 10'd0, 1'b1, 1'b0);

    // Case 4: reset mid-stream drops the held word.
    step(1'b1, 10'd9, 1'b0, 10'd0, 1'b0, 1'b0);
    step(1'b1, 10'd9, 1'b1, 10'd3, 1'b0, 1'b1);
    check("c4_o_valid", o_valid, 0);
    check("c4_o", o, 0);
    step(1'b1, 10'd11, 1'b1, 10'd12, 1'b1, 1'b0);
    check("c4_s", smp_s, 0);
    check("c4_a_ready", smp_ar, 1);

    // Random traffic with occasional reset.
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)), W'($urandom),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 39) == 0));
    end
    repeat (2) step(1'b0, 10'd0, 1'b0, 10'd0, 1'b1, 1'b0);

`ifdef ARB_MUX2_CNT_EN
    // Case 5: counter saturation.
    step(1'b0, 10'd0, 1'b0, 10'd0, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b1, W'(i), 1'b0, 10'd0, 1'b1, 1'b0);
    check("c5_cnt_a", cnt_a, 15);
    check("c5_cnt_b", cnt_b, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/arb_mux2.md
ARB_MUX2 -- requirements
Module: arb_mux2

Interface
REQ-001 The block SHALL have parameter WIDTH, default 1, giving the data width of a, b and o.
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the grant-counter width; it is used only with ARB_MUX2_CNT_EN.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 a  input  WIDTH  source-A data.
REQ-006 a_valid  input  1  source-A data valid.
REQ-007 a_ready  output  1  source-A accepted this cycle when a_valid && a_ready.
REQ-008 b  input  WIDTH  source-B data.
REQ-009 b_valid  input  1  source-B data valid.
REQ-010 b_ready  output  1  source-B accepted this cycle when b_valid && b_ready.
REQ-011 o  output  WIDTH  registered output data.
REQ-012 o_valid  output  1  o holds an untaken word.
REQ-013 o_ready  input  1  consumer takes o when o_valid && o_ready.
REQ-014 s  output  1  current grant (0 = A, 1 = B), the select for the downstream datapath.
REQ-015 cnt_a, cnt_b  output  CNT_W  accepted-word counters; these ports are present only with ARB_MUX2_CNT_EN.

Function
REQ-016 load SHALL equal !o_valid || o_ready, meaning the output register can accept a new word this cycle.
REQ-017 Grant s SHALL be combinational:
- only a_valid asserted: A;
- only b_valid asserted: B;
- both asserted: the source not granted last;
- neither asserted: s holds the last-granted value.
REQ-018 a_ready SHALL equal load && a_valid && s==0, and b_ready SHALL equal load && b_valid && s==1; at most one ready is high per cycle.
REQ-019 On an accepted transfer, o SHALL load the granted source's data one cycle later and o_valid SHALL set, giving 1-cycle latency.
REQ-020 On an accepted transfer, the last-granted bit SHALL update to s; it SHALL NOT change in cycles without a transfer.
REQ-021 If o_ready is high while o_valid is high and no new word is accepted, o_valid SHALL clear next cycle.
REQ-022 A simultaneous take and accept SHALL replace o with no bubble, sustaining one word per cycle.
REQ-023 While o_valid && !o_ready, o and o_valid SHALL hold stable, and both readies SHALL be 0.
REQ-024 The ready outputs SHALL NOT depend combinationally on o itself; they depend only on o_valid, o_ready and the valid inputs.

Reset
REQ-025 When rst is sampled high, next-cycle values SHALL be:
- o_valid = 0;
- o = 0;
- last-granted = 1, so A wins the first contention;
- cnt_a = cnt_b = 0.
REQ-026 While rst is high, a_ready and b_ready SHALL be 0.
REQ-027 Reset asserted mid-stream SHALL discard the registered word without any handshake.

Configuration
REQ-028 With ARB_MUX2_CNT_EN defined, cnt_a and cnt_b SHALL increment on each accepted A or B transfer respectively, saturating at all-ones.
REQ-029 Without ARB_MUX2_CNT_EN, the cnt ports and counter logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-030 A shared package/header SHALL hold the grant encodings GNT_A=0 and GNT_B=1 and the default CNT_W.
REQ-031 The data-select path SHALL be one instance of the existing parameterized 2:1 Mux (a, b, s, o) with WIDTH passed through; the output register follows it.

Verification (WIDTH=10)
REQ-032 Case 1: a=6, a_valid=1, b_valid=0, o_ready=1 -> a_ready=1, s=0; next cycle o=6, o_valid=1.
REQ-033 Case 2: a=6 and b=5 both valid continuously, o_ready=1 -> o sequence 6,5,6,5, one word per cycle, starting with A.
REQ-034 Case 3: o_valid=1 with o_ready=0 for 3 cycles -> o is stable, a_ready=b_ready=0; on o_ready=1, streaming resumes with no lost or duplicated word.
REQ-035 Case 4: rst pulsed for one cycle while o_valid=1 -> next cycle o_valid=0, o=0; the next contention grants A.
REQ-036 Case 5 (ARB_MUX2_CNT_EN, CNT_W=4): 20 A-transfers -> cnt_a=15 (saturated), cnt_b=0.
